// File: rtl/logger_uart_mc.sv
// Multi-source error logger: captures {src, instr, pc} events into a FIFO and
// streams each as an uppercase ASCII hex line to a UART TX over valid/ready.
module logger_uart_mc #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ONESHOT    = 0,
  parameter int unsigned CRLF       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            err_valid,
  input  logic [NUM_SRC*DATA_W-1:0]     err_instr,
  input  logic [NUM_SRC*DATA_W-1:0]     err_pc,
  output logic [7:0]                    uart_data,
  output logic                          uart_valid,
  input  logic                          uart_ready,
  output logic                          busy,
  output logic [7:0]                    drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned H       = DATA_W / 4;
  localparam int unsigned MSG_LEN = 20 + DATA_W / 2 + 2 * CRLF;
  localparam int unsigned EW      = 4 + 2 * DATA_W;
  localparam logic [7:0]  LAST    = 8'(MSG_LEN - 1);
  localparam logic [63:0] PRE     = "RV32I: E";
  localparam logic [23:0] MID     = " 0x";
  localparam logic [63:0] PCS     = " @ PC 0x";

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t              state, state_n;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level_n;
  logic [3:0]          win;
  logic                any_valid, multi, armed, full, push, pop, drop_evt;
  logic [DATA_W-1:0]   win_instr, win_pc;
  logic [EW-1:0]       head;
  logic [3:0]          msg_src;
  logic [DATA_W-1:0]   msg_instr, msg_pc;
  logic [7:0]          byte_idx, idx_n, data_n;
  logic                valid_n;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nib(input logic [DATA_W-1:0] v, input int unsigned k);
    logic [DATA_W-1:0] t;
    t = v << (4 * k);
    return t[DATA_W-1 -: 4];
  endfunction

  function automatic logic [7:0] msg_byte(input int unsigned i, input logic [3:0] s,
                                          input logic [DATA_W-1:0] ins,
                                          input logic [DATA_W-1:0] pc);
    logic [7:0] b;
    b = 8'h0A;
    if (i < 8)               b = 8'(PRE >> (8 * (7 - i)));
    else if (i == 8)         b = hex_char(s);
    else if (i < 12)         b = 8'(MID >> (8 * (11 - i)));
    else if (i < 12 + H)     b = hex_char(nib(ins, i - 12));
    else if (i < 20 + H)     b = 8'(PCS >> (8 * (19 + H - i)));
    else if (i < 20 + 2 * H) b = hex_char(nib(pc, i - 20 - H));
    else if (i == 20 + 2 * H) b = 8'h0D;
    return b;
  endfunction

  // Lowest-index asserted source wins; any second asserted bit is a drop.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (err_valid[i] && !any_valid) begin
        win       = 4'(i);
        any_valid = 1'b1;
      end
    end
  end

  assign multi     = |(err_valid & (err_valid - NUM_SRC'(1)));
  assign win_instr = err_instr[win * DATA_W +: DATA_W];
  assign win_pc    = err_pc[win * DATA_W +: DATA_W];
  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign pop       = (state == LOAD);
  assign push      = armed && any_valid && (!full || pop);
  assign drop_evt  = armed && any_valid && (multi || !push);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (fifo_level != '0);

  always_comb begin
    level_n = fifo_level;
    if (push && !pop)      level_n = fifo_level + LW'(1);
    else if (!push && pop) level_n = fifo_level - LW'(1);
  end

  always_comb begin
    state_n = state;
    valid_n = uart_valid;
    data_n  = uart_data;
    idx_n   = byte_idx;
    unique case (state)
      IDLE: if (fifo_level != '0) state_n = LOAD;
      LOAD: begin
        idx_n   = '0;
        valid_n = 1'b1;
        data_n  = msg_byte(0, head[EW-1 -: 4], head[2*DATA_W-1 -: DATA_W], head[DATA_W-1:0]);
        state_n = SEND;
      end
      SEND: if (uart_valid && uart_ready) begin
        if (byte_idx == LAST) begin
          valid_n = 1'b0;
          state_n = (level_n != '0) ? LOAD : IDLE;
        end else begin
          idx_n  = byte_idx + 8'd1;
          data_n = msg_byte(32'(byte_idx) + 32'd1, msg_src, msg_instr, msg_pc);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {win, win_instr, win_pc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      uart_valid <= 1'b0;
      uart_data  <= '0;
      byte_idx   <= '0;
      fifo_level <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_cnt   <= '0;
      armed      <= 1'b1;
      msg_src    <= '0;
      msg_instr  <= '0;
      msg_pc     <= '0;
    end else begin
      state      <= state_n;
      uart_valid <= valid_n;
      uart_data  <= data_n;
      byte_idx   <= idx_n;
      fifo_level <= level_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        msg_src   <= head[EW-1 -: 4];
        msg_instr <= head[2*DATA_W-1 -: DATA_W];
        msg_pc    <= head[DATA_W-1:0];
      end
      if (drop_evt && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
      if (ONESHOT != 0 && push) armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logger_uart_mc.sv
// Scoreboard bench for logger_uart_mc: a continuous-mode and a one-shot instance.
module tb_logger_uart_mc;

  logic         clk = 1'b0;
  logic         rst, rst_os;
  logic [3:0]   err_valid, err_valid_os;
  logic [127:0] err_instr, err_pc;
  logic         uart_ready, uart_ready_os;
  logic [7:0]   uart_data, uart_data_os, drop_cnt, drop_cnt_os;
  logic         uart_valid, uart_valid_os, busy, busy_os;
  logic [2:0]   fifo_level, fifo_level_os;

  int           n_checks = 0;
  int           n_fail = 0;
  int           rx_cnt = 0;
  int           rx_cnt_os = 0;
  int           exp_drop = 0;
  logic [7:0]   exp_q[$];
  logic [7:0]   exp_q_os[$];
  logic [7:0]   e_byte, e_byte_os, stall_data;
  logic         stall_pend = 1'b0;

  always #5 clk = ~clk;

  logger_uart_mc #(.NUM_SRC(4), .DATA_W(32), .FIFO_DEPTH(4), .ONESHOT(0), .CRLF(1)) u_dut (
    .clk(clk), .rst(rst), .err_valid(err_valid), .err_instr(err_instr), .err_pc(err_pc),
    .uart_data(uart_data), .uart_valid(uart_valid), .uart_ready(uart_ready),
    .busy(busy), .drop_cnt(drop_cnt), .fifo_level(fifo_level));

  logger_uart_mc #(.NUM_SRC(4), .DATA_W(32), .FIFO_DEPTH(4), .ONESHOT(1), .CRLF(1)) u_dut_os (
    .clk(clk), .rst(rst_os), .err_valid(err_valid_os), .err_instr(err_instr), .err_pc(err_pc),
    .uart_data(uart_data_os), .uart_valid(uart_valid_os), .uart_ready(uart_ready_os),
    .busy(busy_os), .drop_cnt(drop_cnt_os), .fifo_level(fifo_level_os));

  // Byte stream scoreboard plus hold-while-stalled check, main instance.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        n_checks++;
        if (uart_valid !== 1'b1 || uart_data !== stall_data) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                   uart_valid, uart_data, stall_data);
        end
      end
      stall_pend = 1'b0;
      if (uart_valid === 1'b1 && uart_ready === 1'b0) begin
        stall_pend = 1'b1;
        stall_data = uart_data;
      end
      if (uart_valid === 1'b1 && uart_ready === 1'b1) begin
        n_checks++;
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL byte_stream: got %h, required no byte", uart_data);
        end else begin
          e_byte = exp_q.pop_front();
          if (uart_data !== e_byte) begin
            n_fail++;
            $display("FAIL byte_stream: byte %0d got %h, required %h", rx_cnt, uart_data, e_byte);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_os && uart_valid_os === 1'b1 && uart_ready_os === 1'b1) begin
      n_checks++;
      rx_cnt_os++;
      if (exp_q_os.size() == 0) begin
        n_fail++;
        $display("FAIL os_byte_stream: got %h, required no byte", uart_data_os);
      end else begin
        e_byte_os = exp_q_os.pop_front();
        if (uart_data_os !== e_byte_os) begin
          n_fail++;
          $display("FAIL os_byte_stream: byte %0d got %h, required %h", rx_cnt_os, uart_data_os, e_byte_os);
        end
      end
    end
  end

  task automatic expect_line(input bit os, input int src, input logic [31:0] ins, input logic [31:0] pc);
    string a, b, s;
    a = $sformatf("%08x", ins);
    b = $sformatf("%08x", pc);
    s = $sformatf("RV32I: E%0d 0x%s @ PC 0x%s\r\n", src, a.toupper(), b.toupper());
    for (int i = 0; i < s.len(); i++) begin
      if (os) exp_q_os.push_back(s[i]);
      else    exp_q.push_back(s[i]);
    end
  endtask

  // Called just after a rising edge; the event is sampled on the next edge.
  task automatic pulse(input bit os, input logic [3:0] mask, input logic [31:0] ins, input logic [31:0] pc);
    for (int s = 0; s < 4; s++) begin
      err_instr[s*32 +: 32] = ins;
      err_pc[s*32 +: 32]    = pc;
    end
    if (os) err_valid_os = mask;
    else    err_valid    = mask;
    @(posedge clk); #1;
    err_valid    = '0;
    err_valid_os = '0;
  endtask

  task automatic wait_drain(input bit os, input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if ((os ? exp_q_os.size() : exp_q.size()) == 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst_os = 1'b1;
    err_valid = '0; err_valid_os = '0; err_instr = '0; err_pc = '0;
    uart_ready = 1'b0; uart_ready_os = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({uart_data, uart_valid, busy, drop_cnt, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: data=%h valid=%b busy=%b drop=%0d level=%0d, required all 0",
               uart_data, uart_valid, busy, drop_cnt, fifo_level);
    end
    rst = 1'b0; rst_os = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({uart_valid, busy, fifo_level, uart_valid_os, busy_os} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: valid=%b busy=%b level=%0d, required 0 0 0", uart_valid, busy, fifo_level);
    end
    exp_drop = 0;
  endtask

  task automatic test_single;
    bit to;
    uart_ready = 1'b1;
    rx_cnt = 0;
    expect_line(0, 2, 32'hDEADBEEF, 32'h00000104);
    pulse(0, 4'b0100, 32'hDEADBEEF, 32'h00000104);
    n_checks++;
    if (fifo_level !== 3'd1) begin
      n_fail++; $display("FAIL single_level_e0: got %0d, required 1", fifo_level);
    end
    @(posedge clk); #1;
    n_checks++;
    if (uart_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_load_cycle: valid=%b busy=%b, required 0 1", uart_valid, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (uart_valid !== 1'b1 || uart_data !== 8'h52) begin
      n_fail++; $display("FAIL single_first_byte: valid=%b data=%h, required 1 52", uart_valid, uart_data);
    end
    wait_drain(0, 100, to);
    n_checks++;
    if (to || busy !== 1'b0 || uart_valid !== 1'b0 || rx_cnt != 38) begin
      n_fail++;
      $display("FAIL single_end: timeout=%0b busy=%b valid=%b bytes=%0d, required 0 0 0 38", to, busy, uart_valid, rx_cnt);
    end
  endtask

  task automatic test_backpressure;
    bit done;
    rx_cnt = 0;
    done = 1'b0;
    expect_line(0, 2, 32'hDEADBEEF, 32'h00000104);
    pulse(0, 4'b0100, 32'hDEADBEEF, 32'h00000104);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin done = 1'b1; break; end
      uart_ready = 1'($urandom_range(0, 1));
    end
    uart_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (!done || busy !== 1'b0 || rx_cnt != 38) begin
      n_fail++; $display("FAIL backpressure_end: done=%0b busy=%b bytes=%0d, required 1 0 38", done, busy, rx_cnt);
    end
  endtask

  task automatic test_simultaneous;
    bit to;
    uart_ready = 1'b1;
    expect_line(0, 0, 32'h0BADF00D, 32'h80000010);
    pulse(0, 4'b1001, 32'h0BADF00D, 32'h80000010);
    exp_drop++;
    n_checks++;
    if (drop_cnt !== 8'(exp_drop) || fifo_level !== 3'd1) begin
      n_fail++; $display("FAIL simultaneous_drop: drop=%0d level=%0d, required %0d 1", drop_cnt, fifo_level, exp_drop);
    end
    wait_drain(0, 100, to);
    n_checks++;
    if (to || busy !== 1'b0) begin
      n_fail++; $display("FAIL simultaneous_end: timeout=%0b busy=%b, required 0 0", to, busy);
    end
  endtask

  task automatic test_back_to_back;
    bit seen, done;
    int gap;
    seen = 1'b0; done = 1'b0; gap = 0;
    uart_ready = 1'b1;
    expect_line(0, 1, 32'h11112222, 32'h00001000);
    expect_line(0, 3, 32'hA5A5C3C3, 32'h00002004);
    pulse(0, 4'b0010, 32'h11112222, 32'h00001000);
    pulse(0, 4'b1000, 32'hA5A5C3C3, 32'h00002004);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (uart_valid === 1'b1) seen = 1'b1;
      else if (seen && busy === 1'b1) gap++;
      if (seen && busy === 1'b0 && exp_q.size() == 0) begin done = 1'b1; break; end
    end
    n_checks++;
    if (!done || gap != 1 || drop_cnt !== 8'(exp_drop)) begin
      n_fail++; $display("FAIL back_to_back: done=%0b gap=%0d drop=%0d, required 1 1 %0d", done, gap, drop_cnt, exp_drop);
    end
  endtask

  task automatic test_overflow;
    bit to, left;
    uart_ready = 1'b0;
    expect_line(0, 1, 32'h10000000, 32'h00000400);
    pulse(0, 4'b0010, 32'h10000000, 32'h00000400);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) expect_line(0, 1, 32'h10000000 + 32'(k), 32'h00000400 + 32'(4 * k));
      pulse(0, 4'b0010, 32'h10000000 + 32'(k), 32'h00000400 + 32'(4 * k));
    end
    exp_drop += 2;
    n_checks++;
    if (fifo_level !== 3'd4 || drop_cnt !== 8'(exp_drop)) begin
      n_fail++; $display("FAIL overflow_full: level=%0d drop=%0d, required 4 %0d", fifo_level, drop_cnt, exp_drop);
    end
    uart_ready = 1'b1;
    left = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (uart_valid === 1'b0) begin left = 1'b0; break; end
    end
    // In LOAD with a full FIFO: this edge both pops and pushes.
    expect_line(0, 2, 32'hFFFF0000, 32'h00000500);
    pulse(0, 4'b0100, 32'hFFFF0000, 32'h00000500);
    n_checks++;
    if (left || fifo_level !== 3'd4 || drop_cnt !== 8'(exp_drop)) begin
      n_fail++; $display("FAIL overflow_push_pop: timeout=%0b level=%0d drop=%0d, required 0 4 %0d", left, fifo_level, drop_cnt, exp_drop);
    end
    wait_drain(0, 400, to);
    n_checks++;
    if (to || busy !== 1'b0) begin
      n_fail++; $display("FAIL overflow_drain: timeout=%0b busy=%b, required 0 0", to, busy);
    end
  endtask

  task automatic test_reset_mid;
    bit to, reached;
    uart_ready = 1'b1;
    rx_cnt = 0;
    reached = 1'b0;
    expect_line(0, 0, 32'hCAFEBABE, 32'h00000200);
    expect_line(0, 1, 32'h12345678, 32'h00000300);
    pulse(0, 4'b0001, 32'hCAFEBABE, 32'h00000200);
    pulse(0, 4'b0010, 32'h12345678, 32'h00000300);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rx_cnt >= 10) begin reached = 1'b1; break; end
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (!reached || uart_valid !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: reached=%0b valid=%b level=%0d busy=%b drop=%0d, required 1 0 0 0 0",
               reached, uart_valid, fifo_level, busy, drop_cnt);
    end
    exp_q.delete();
    rx_cnt = 0;
    exp_drop = 0;
    #4 rst = 1'b0;
    @(posedge clk); #1;
    expect_line(0, 3, 32'h00C0FFEE, 32'h0000FFFC);
    pulse(0, 4'b1000, 32'h00C0FFEE, 32'h0000FFFC);
    wait_drain(0, 100, to);
    n_checks++;
    if (to || rx_cnt != 38 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_resume: timeout=%0b bytes=%0d busy=%b, required 0 38 0", to, rx_cnt, busy);
    end
  endtask

  task automatic test_oneshot;
    bit to;
    uart_ready_os = 1'b1;
    rx_cnt_os = 0;
    expect_line(1, 0, 32'h00000001, 32'h00000010);
    pulse(1, 4'b0001, 32'h00000001, 32'h00000010);
    pulse(1, 4'b0010, 32'h00000002, 32'h00000020);
    pulse(1, 4'b0110, 32'h00000003, 32'h00000030);
    n_checks++;
    if (drop_cnt_os !== 8'd0) begin
      n_fail++; $display("FAIL oneshot_drop: got %0d, required 0", drop_cnt_os);
    end
    wait_drain(1, 100, to);
    repeat (60) @(posedge clk);
    #1;
    n_checks++;
    if (to || rx_cnt_os != 38 || busy_os !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_single_line: timeout=%0b bytes=%0d busy=%b, required 0 38 0", to, rx_cnt_os, busy_os);
    end
    rst_os = 1'b1;
    @(posedge clk); #1;
    rst_os = 1'b0;
    expect_line(1, 2, 32'h87654321, 32'h00000040);
    pulse(1, 4'b0100, 32'h87654321, 32'h00000040);
    wait_drain(1, 100, to);
    n_checks++;
    if (to || rx_cnt_os != 76 || drop_cnt_os !== 8'd0) begin
      n_fail++; $display("FAIL oneshot_rearm: timeout=%0b bytes=%0d drop=%0d, required 0 76 0", to, rx_cnt_os, drop_cnt_os);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_oneshot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
